halt_dump_ctrl: RTL

//  Run/halt sequencer for the 16-bit cpu. Watches the fetched instruction for a halt encoding,

---
 rtl/halt_dump_ctrl_pkg.sv | 26 ++
 rtl/halt_dump_ctrl_if.sv | 27 ++
 rtl/halt_dump_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/halt_dump_ctrl_pkg.sv
// Package for halt_dump_ctrl.
// Holds the sequencer state encoding, the two halt opcodes and the halt decoder.
package halt_dump_ctrl_pkg;

  localparam int unsigned INSTR_W   = 16;
  localparam int unsigned REG_IDX_W = 4;

  localparam logic [INSTR_W-1:0] HALT_A = 16'hE000;
  localparam logic [INSTR_W-1:0] HALT_B = 16'hE7FF;

  typedef enum logic [2:0] {
    RUN,
    DRAIN,
    REGS,
    RD,
    WAIT,
    EMIT,
    DONE
  } state_e;

  // Only the two exact encodings halt; neighbouring opcodes do not.
  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return (instr == HALT_A) || (instr == HALT_B);
  endfunction

endpackage

// File: rtl/halt_dump_ctrl_if.sv
// Data-memory read port plus ready/valid dump stream of halt_dump_ctrl.
//   master: the controller (drives mem_sel/mem_addr and the dump_* payload)
//   slave : memory + dump consumer (drives mem_rdata and dump_ready)
interface halt_dump_ctrl_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);

  logic              mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;

  modport master (
    output mem_sel, mem_addr, dump_valid, dump_addr, dump_data,
    input  mem_rdata, dump_ready
  );

  modport slave (
    input  mem_sel, mem_addr, dump_valid, dump_addr, dump_data,
    output mem_rdata, dump_ready
  );

endinterface

// File: rtl/halt_dump_ctrl.sv
// Run/halt sequencer: detects a halt opcode in fetch, drains the pipeline for
// DRAIN_CYCLES, then owns the dmem read port and streams every non-zero word
// out over a ready/valid dump channel.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   instr             instruction in fetch
//   clear             DONE -> RUN re-arm pulse
//   halted            halt seen; held until reset/clear
//   bus (master)      mem_sel/mem_addr/mem_rdata (1-cycle read latency) and
//                     dump_valid/dump_ready/dump_addr/dump_data
//   done              scan complete; held until reset/clear
//   dump_count        words accepted by the consumer
// Optional build macro DUMP_REGS_EN adds reg_raddr/reg_rdata/dump_is_reg and
// dumps the 16 register-file entries before the memory scan.
module halt_dump_ctrl
  import halt_dump_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned DRAIN_CYCLES = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [INSTR_W-1:0]   instr,
  input  logic                 clear,
  output logic                 halted,
  halt_dump_ctrl_if.master     bus,
  output logic                 done,
  output logic [ADDR_W:0]      dump_count
`ifdef DUMP_REGS_EN
  ,
  output logic [REG_IDX_W-1:0] reg_raddr,
  input  logic [DATA_W-1:0]    reg_rdata,
  output logic                 dump_is_reg
`endif
);

  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_e              state_q, state_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic                halted_q, halted_d;
  logic                mem_sel_q, mem_sel_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   daddr_q, daddr_d;
  logic [DATA_W-1:0]   ddata_q, ddata_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                adv;
`ifdef DUMP_REGS_EN
  logic [REG_IDX_W-1:0] ridx_q, ridx_d;
  logic                 is_reg_q, is_reg_d;
`endif

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      drain_q    <= '0;
      halted_q   <= 1'b0;
      mem_sel_q  <= 1'b0;
      mem_addr_q <= '0;
      valid_q    <= 1'b0;
      daddr_q    <= '0;
      ddata_q    <= '0;
      done_q     <= 1'b0;
      count_q    <= '0;
`ifdef DUMP_REGS_EN
      ridx_q     <= '0;
      is_reg_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      halted_q   <= halted_d;
      mem_sel_q  <= mem_sel_d;
      mem_addr_q <= mem_addr_d;
      valid_q    <= valid_d;
      daddr_q    <= daddr_d;
      ddata_q    <= ddata_d;
      done_q     <= done_d;
      count_q    <= count_d;
`ifdef DUMP_REGS_EN
      ridx_q     <= ridx_d;
      is_reg_q   <= is_reg_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    halted_d   = halted_q;
    mem_sel_d  = mem_sel_q;
    mem_addr_d = mem_addr_q;
    valid_d    = valid_q;
    daddr_d    = daddr_q;
    ddata_d    = ddata_q;
    done_d     = done_q;
    count_d    = count_q;
    adv        = 1'b0;
`ifdef DUMP_REGS_EN
    ridx_d     = ridx_q;
    is_reg_d   = is_reg_q;
`endif

    case (state_q)
      RUN: begin
        if (is_halt(instr)) begin
          halted_d = 1'b1;
          drain_d  = DRAIN_W'(DRAIN_CYCLES - 1);
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_q == '0) begin
          mem_sel_d  = 1'b1;
          mem_addr_d = '0;
`ifdef DUMP_REGS_EN
          ridx_d     = '0;
          state_d    = REGS;
`else
          state_d    = RD;
`endif
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
`ifdef DUMP_REGS_EN
      // Load one register, then hold it until accepted; zeros are dumped too.
      REGS: begin
        if (!valid_q) begin
          valid_d  = 1'b1;
          ddata_d  = reg_rdata;
          daddr_d  = ADDR_W'(ridx_q);
          is_reg_d = 1'b1;
        end else if (bus.dump_ready) begin
          valid_d = 1'b0;
          count_d = count_q + CNT_W'(1);
          if (ridx_q == '1) begin
            state_d = RD;
          end else begin
            ridx_d = ridx_q + REG_IDX_W'(1);
          end
        end
      end
`endif
      RD: begin
        state_d = WAIT;
      end
      WAIT: begin
        ddata_d = bus.mem_rdata;
        daddr_d = mem_addr_q;
`ifdef DUMP_REGS_EN
        is_reg_d = 1'b0;
`endif
        if (bus.mem_rdata != '0) begin
          valid_d = 1'b1;
          state_d = EMIT;
        end else begin
          adv = 1'b1;
        end
      end
      EMIT: begin
        if (bus.dump_ready) begin
          valid_d = 1'b0;
          count_d = count_q + CNT_W'(1);
          adv     = 1'b1;
        end
      end
      DONE: begin
        if (clear) begin
          state_d  = RUN;
          halted_d = 1'b0;
          done_d   = 1'b0;
          count_d  = '0;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // Step to the next address, or finish at the top of memory without wrapping.
    if (adv) begin
      if (mem_addr_q == ADDR_LAST) begin
        state_d   = DONE;
        done_d    = 1'b1;
        mem_sel_d = 1'b0;
      end else begin
        mem_addr_d = mem_addr_q + ADDR_W'(1);
        state_d    = RD;
      end
    end
  end

  assign halted         = halted_q;
  assign done           = done_q;
  assign dump_count     = count_q;
  assign bus.mem_sel    = mem_sel_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.dump_valid = valid_q;
  assign bus.dump_addr  = daddr_q;
  assign bus.dump_data  = ddata_q;
`ifdef DUMP_REGS_EN
  assign reg_raddr      = ridx_q;
  assign dump_is_reg    = is_reg_q;
`endif

endmodule
